// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter
//   Shares one word-wide memory read port between the per-core cache
//   controllers. One core is granted at a time (round-robin) and its whole
//   line is fetched as a critical-word-first burst. Returned words are
//   steered back to the granted core together with their line word index.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   req_i           per-core line-fill request, held until fill_done_o
//   req_addr_i      per-core byte address, core k at [k*ADDR_SIZE +: ADDR_SIZE]
//   grant_o         one-hot, core currently being served
//   fill_valid_o    one-hot, returned word valid for that core
//   fill_data_o     returned word (straight from mem_rdata_i)
//   fill_word_o     line word index of fill_data_o
//   fill_done_o     one-hot pulse on the last word of the burst
//   mem_req_o       word read request
//   mem_addr_o      word-aligned read address
//   mem_ready_i     memory accepts the request this cycle
//   mem_rvalid_i    in-order read data valid
//   mem_rdata_i     read data
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant; pick next requester round-robin from last_q+1
// BURST | grant held; issue and collect WORDS_PER_LINE words
// GAP   | one dead cycle so the finished core can drop req_i
module line_fill_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_SIZE      = 32,
    parameter int DATA_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CORES-1:0]              req_i,
    input  logic [NUM_CORES*ADDR_SIZE-1:0]    req_addr_i,
    output logic [NUM_CORES-1:0]              grant_o,
    output logic [NUM_CORES-1:0]              fill_valid_o,
    output logic [DATA_SIZE-1:0]              fill_data_o,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word_o,
    output logic [NUM_CORES-1:0]              fill_done_o,
    output logic                              mem_req_o,
    output logic [ADDR_SIZE-1:0]              mem_addr_o,
    input  logic                              mem_ready_i,
    input  logic                              mem_rvalid_i,
    input  logic [DATA_SIZE-1:0]              mem_rdata_i
);

    localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int IDX_W     = $clog2(NUM_CORES);
    localparam int CNT_W     = WORD_BITS + 1;
    localparam int OFF_BITS  = WORD_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORDS_PER_LINE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]           state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     last_q;
    logic [ADDR_SIZE-1:0] base_q;
    logic [WORD_BITS-1:0] start_q;
    logic [CNT_W-1:0]     issue_cnt;
    logic [CNT_W-1:0]     rx_cnt;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [ADDR_SIZE-1:0] sel_addr;

    logic                 in_burst;
    logic                 issue_fire;
    logic                 rx_fire;
    logic                 rx_last;
    logic [NUM_CORES-1:0] idx_onehot;
    logic [WORD_BITS-1:0] issue_word;
    logic [WORD_BITS-1:0] rx_word;

    // Rotating priority: search upward from the core after the last one served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            if (!sel_found && req_i[(int'(last_q) + i) % NUM_CORES]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'((int'(last_q) + i) % NUM_CORES);
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                sel_addr = req_addr_i[k*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

    assign in_burst   = (state_q == ST_BURST);
    assign idx_onehot = NUM_CORES'(1) << idx_q;

    // Word index arithmetic is WORD_BITS wide, so the wrap to the start of
    // the line falls out of the natural overflow.
    assign issue_word = start_q + issue_cnt[WORD_BITS-1:0];
    assign rx_word    = start_q + rx_cnt[WORD_BITS-1:0];

    assign mem_req_o  = in_burst && (issue_cnt < CNT_MAX);
    assign issue_fire = mem_req_o && mem_ready_i;
    assign rx_fire    = in_burst && mem_rvalid_i && (rx_cnt < CNT_MAX);
    assign rx_last    = (rx_cnt == CNT_MAX - 1'b1);

    assign grant_o      = in_burst ? idx_onehot : '0;
    assign mem_addr_o   = in_burst ?
                          (base_q | {{(ADDR_SIZE-OFF_BITS){1'b0}}, issue_word, 2'b00}) : '0;
    assign fill_valid_o = rx_fire ? idx_onehot : '0;
    assign fill_word_o  = rx_fire ? rx_word : '0;
    assign fill_done_o  = (rx_fire && rx_last) ? idx_onehot : '0;
    assign fill_data_o  = mem_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            last_q    <= IDX_W'(NUM_CORES - 1);
            base_q    <= '0;
            start_q   <= '0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_found) begin
                        idx_q     <= sel_idx;
                        base_q    <= {sel_addr[ADDR_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
                        start_q   <= sel_addr[OFF_BITS-1:2];
                        issue_cnt <= '0;
                        rx_cnt    <= '0;
                        state_q   <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (issue_fire) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (rx_fire) begin
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_last) begin
                            last_q  <= idx_q;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/line_fill_arbiter.md
# line_fill_arbiter

Round-robin arbiter and burst sequencer that shares one word-wide memory read port between the per-core cache controllers of the multicore processor. It grants one requester at a time and fetches that requester's full cache line as a critical-word-first burst of WORDS_PER_LINE words. Each returned word is steered back to the granted core with its word index. It sits between the core caches and the shared memory interface.

## Interface
- NUM_CORES, 4: number of requesting cores, minimum 2.
- ADDR_SIZE, 32: byte address width.
- DATA_SIZE, 32: word width.
- WORDS_PER_LINE, 8: words per cache line, power of two. WORD_BITS = $clog2(WORDS_PER_LINE); byte offset is 2 bits.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  NUM_CORES  line-fill request, one bit per core; held until that core's fill_done_o.
- req_addr_i  in  NUM_CORES*ADDR_SIZE  requested byte address, core k in bits [k*ADDR_SIZE +: ADDR_SIZE]; stable while req_i[k] is high.
- grant_o  out  NUM_CORES  one-hot; the currently served core.
- fill_valid_o  out  NUM_CORES  one-hot; a returned word is valid for that core this cycle.
- fill_data_o  out  DATA_SIZE  returned word, shared by all cores; equals mem_rdata_i.
- fill_word_o  out  WORD_BITS  line word index of fill_data_o.
- fill_done_o  out  NUM_CORES  one-cycle pulse on the last word of the burst.
- mem_req_o  out  1  word read request.
- mem_addr_o  out  ADDR_SIZE  word-aligned read address.
- mem_ready_i  in  1  memory accepts the request this cycle.
- mem_rvalid_i  in  1  read data valid; responses return in order.
- mem_rdata_i  in  DATA_SIZE  read data.

## Operation
- FSM states are IDLE, BURST and GAP.
- **IDLE**
  - If any req_i bit is set, select the first set bit searching upward, modulo NUM_CORES, from last_q+1.
  - Latch: idx_q = the selected core; base_q = req_addr_i[idx] with its low $clog2(WORDS_PER_LINE)+2 bits cleared; start_q = req_addr_i[idx][WORD_BITS+1:2].
  - Set issue_cnt and rx_cnt to 0, then go to BURST.
  - If no req_i bit is set, stay in IDLE.
- **BURST**
  - grant_o = one-hot(idx_q).
  - mem_req_o = (issue_cnt < WORDS_PER_LINE).
  - mem_addr_o = base_q | ((start_q + issue_cnt) mod WORDS_PER_LINE) << 2. The word index wraps, giving critical-word-first order.
  - When mem_req_o & mem_ready_i, increment issue_cnt.
  - When mem_rvalid_i:
    - fill_valid_o[idx_q] = 1.
    - fill_word_o = (start_q + rx_cnt) mod WORDS_PER_LINE.
    - Increment rx_cnt.
  - On the rvalid that makes rx_cnt reach WORDS_PER_LINE:
    - Pulse fill_done_o[idx_q] in that same cycle.
    - Set last_q = idx_q and go to GAP.
  - Issue and return overlap; a response can arrive in the same cycle as a new issue.
- **GAP**
  - Lasts one cycle, with grant_o = 0 and mem_req_o = 0, then returns to IDLE.
  - This gives the finished requester time to drop req_i.
  - If that core's req_i is still high in IDLE, it is a new request. It now has the lowest priority because of the rotation.
- **Boundary behaviour**
  - req_i dropping mid-burst: the burst completes and grant is held.
  - req_addr_i changing mid-burst: ignored; values are latched.
  - mem_rvalid_i in IDLE or GAP: ignored, with no fill_valid_o.
  - mem_ready_i while mem_req_o = 0: ignored.
  - issue_cnt and rx_cnt saturate at WORDS_PER_LINE.
  - fill_data_o is combinational from mem_rdata_i. It is meaningful only when fill_valid_o is set.
- **Reset (rst_n low, any state)**
  - Go to IDLE and abandon any burst; the memory side must be reset together with this block.
  - Reset values: grant_o = 0, fill_valid_o = 0, fill_done_o = 0, mem_req_o = 0, mem_addr_o = 0, fill_word_o = 0, counters = 0.
  - last_q = NUM_CORES-1, so core 0 has top priority after reset.

## Timing
- Request seen in IDLE at cycle N: grant_o and the first mem_req_o are registered and visible at N+1.
- The first issued address is the critical word.
- Example, mem_ready_i always 1 and rvalid one cycle after acceptance:
  - issues occur at N+1..N+8;
  - data returns at N+2..N+9;
  - fill_done_o is at N+9, GAP at N+10, IDLE at N+11.
  - The next grant is visible at N+12.
- Back-to-back grants are separated by 3 cycles: the done cycle, GAP and IDLE.
- mem_req_o and mem_addr_o hold steady while mem_ready_i is low.

## Test plan
- **Single request with wrap**
  - Stimulus: core 2 requests addr 0x0000_1234; ready = 1; rvalid latency 1.
  - Required: mem_addr_o sequence 0x1234, 0x1238, 0x123C, 0x1220, 0x1224, 0x1228, 0x122C, 0x1230.
  - Required: fill_word_o sequence 5,6,7,0,1,2,3,4.
  - Required: one fill_done_o[2] pulse at N+9.
- **Round-robin**
  - Stimulus: all four cores request continuously from reset.
  - Required: grant order 0,1,2,3,0, each covering 8 words; grant_o is never multi-hot.
- **Backpressure**
  - Stimulus: mem_ready_i low on every other cycle; rvalid delayed 3 cycles.
  - Required: exactly 8 issues with addresses stable while stalled; 8 fills; a single fill_done_o pulse.
- **Request drop mid-burst**
  - Stimulus: core 1 deasserts req_i after its 3rd word.
  - Required: the burst still completes with 8 fill_valid_o[1] pulses, followed by GAP and IDLE.
- **Stray rvalid**
  - Stimulus: mem_rvalid_i pulses in IDLE and in GAP.
  - Required: no fill_valid_o or fill_done_o activity; counters unchanged.
- **Reset mid-burst**
  - Stimulus: rst_n pulled low after word 4.
  - Required: all outputs go to 0 asynchronously. The next request from core 3 alone is granted, and core 0 wins ties after reset.
